// File: rtl/riscv_pkg.sv
// Shared RISC-V encoding constants, instruction-format type and immediate packer
// used by the immediate encoder and its output FIFO.
package riscv_pkg;

    localparam int unsigned INSTR_W        = 32;
    localparam int unsigned IMM_W          = 12;
    localparam int unsigned DEFAULT_ADDR_W = 10;
    localparam int unsigned DEFAULT_DEPTH  = 2;

    localparam logic [6:0] OPCODE_LOAD  = 7'b0000011;
    localparam logic [6:0] OPCODE_STORE = 7'b0100011;

    typedef enum logic {
        FMT_I = 1'b0,
        FMT_S = 1'b1
    } fmt_e;

    // S-type splits the immediate around rs1/funct3; I-type keeps it contiguous at the top
    function automatic logic [INSTR_W-1:0] encode_imm(
        input fmt_e             fmt,
        input logic [6:0]       opcode,
        input logic [2:0]       funct3,
        input logic [4:0]       rs1,
        input logic [4:0]       rd_rs2,
        input logic [IMM_W-1:0] imm12
    );
        logic [INSTR_W-1:0] word;
        if (fmt == FMT_S) begin
            word = {imm12[11:5], rd_rs2, rs1, funct3, imm12[4:0], opcode};
        end else begin
            word = {imm12, rs1, funct3, rd_rs2, opcode};
        end
        return word;
    endfunction

endpackage

// File: rtl/enc_fifo.sv
// Registered-output FIFO holding encoded words with their word addresses.
// Push is refused when full even if a pop happens in the same cycle.
module enc_fifo
    import riscv_pkg::*;
#(
    parameter int unsigned W     = INSTR_W + DEFAULT_ADDR_W,
    parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic         full,
    output logic         valid,
    output logic [W-1:0] dout
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_nxt_c;
    logic             do_push_c;
    logic             do_pop_c;

    assign do_push_c = push && !full;
    assign do_pop_c  = pop && valid;
    assign dout      = mem[rd_ptr];

    // Occupancy next-state; flags are registered from it
    always_comb begin
        count_nxt_c = count;
        if (clr) begin
            count_nxt_c = '0;
        end else begin
            case ({do_push_c, do_pop_c})
                2'b10:   count_nxt_c = count + CNT_W'(1);
                2'b01:   count_nxt_c = count - CNT_W'(1);
                default: count_nxt_c = count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            valid  <= 1'b0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else begin
            count <= count_nxt_c;
            full  <= (count_nxt_c == CNT_W'(DEPTH));
            valid <= (count_nxt_c != '0);
            if (clr) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (do_push_c) begin
                    mem[wr_ptr] <= din;
                    wr_ptr      <= wr_ptr + PTR_W'(1);
                end
                if (do_pop_c) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/imm_encoder.sv
// Packs a signed immediate into an I-type or S-type instruction word, tags it
// with a running word address, and queues it; out-of-range immediates are counted.
module imm_encoder
    import riscv_pkg::*;
#(
    parameter int unsigned ADDR_W = DEFAULT_ADDR_W,
    parameter int unsigned DEPTH  = DEFAULT_DEPTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               sel,
    input  logic [6:0]         opcode,
    input  logic [2:0]         funct3,
    input  logic [4:0]         rs1,
    input  logic [4:0]         rd_rs2,
    input  logic [31:0]        imm,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [31:0]        out_instr,
    output logic [ADDR_W-1:0]  out_addr,
    output logic               err_pulse,
    output logic [7:0]         err_count
);

    localparam int unsigned ENTRY_W = INSTR_W + ADDR_W;

    logic               full;
    logic               in_range_c;
    logic               accept_c;
    logic               push_c;
    logic               reject_c;
    fmt_e               fmt_c;
    logic [INSTR_W-1:0] word_c;
    logic [ADDR_W-1:0]  wr_addr;
    logic [ENTRY_W-1:0] fifo_dout;

    // Fits in 12 signed bits when the sign bit and everything above it agree
    assign in_range_c = (imm[31:IMM_W-1] == '0) || (imm[31:IMM_W-1] == '1);
    assign in_ready   = !full;
    assign accept_c   = in_valid && in_ready;
    assign push_c     = accept_c && in_range_c && !clr;
    assign reject_c   = accept_c && !in_range_c && !clr;
    assign fmt_c      = sel ? FMT_S : FMT_I;
    assign word_c     = encode_imm(fmt_c, opcode, funct3, rs1, rd_rs2, imm[IMM_W-1:0]);

    enc_fifo #(
        .W     (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .push  (push_c),
        .din   ({word_c, wr_addr}),
        .pop   (out_ready),
        .full  (full),
        .valid (out_valid),
        .dout  (fifo_dout)
    );

    assign out_instr = fifo_dout[ADDR_W +: INSTR_W];
    assign out_addr  = fifo_dout[ADDR_W-1:0];

    // Address counter advances only on accepted pushes; error stats saturate
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_addr   <= '0;
            err_pulse <= 1'b0;
            err_count <= '0;
        end else if (clr) begin
            wr_addr   <= '0;
            err_pulse <= 1'b0;
            err_count <= '0;
        end else begin
            err_pulse <= reject_c;
            if (push_c) begin
                wr_addr <= wr_addr + ADDR_W'(1);
            end
            if (reject_c && (err_count != 8'hFF)) begin
                err_count <= err_count + 8'(1);
            end
        end
    end

endmodule

// File: tb/tb_imm_encoder.sv
// Self-checking bench for imm_encoder: directed scenarios plus a randomized run
// against a queue-based reference model that works from integer immediates.
module tb_imm_encoder;
    import riscv_pkg::*;

    localparam int unsigned AW = 10;
    localparam int unsigned DP = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          clr;
    logic          in_valid;
    logic          in_ready;
    logic          sel;
    logic [6:0]    opcode;
    logic [2:0]    funct3;
    logic [4:0]    rs1;
    logic [4:0]    rd_rs2;
    logic [31:0]   imm;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_instr;
    logic [AW-1:0] out_addr;
    logic          err_pulse;
    logic [7:0]    err_count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0]   instr;
        logic [AW-1:0] addr;
        int            im;
        bit            s;
    } exp_t;

    exp_t          exp_q[$];
    logic [AW-1:0] exp_addr;
    int            exp_errc;
    bit            exp_pulse;

    imm_encoder #(.ADDR_W(AW), .DEPTH(DP)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sel       (sel),
        .opcode    (opcode),
        .funct3    (funct3),
        .rs1       (rs1),
        .rd_rs2    (rd_rs2),
        .imm       (imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_addr  (out_addr),
        .err_pulse (err_pulse),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    // Reference: field placement by shifts of a 12-bit two's-complement value
    function automatic logic [31:0] ref_enc(input bit s, input logic [6:0] op, input logic [2:0] f3,
                                            input logic [4:0] r1, input logic [4:0] r2, input int im);
        logic [31:0] u;
        u = 32'(im) & 32'hFFF;
        if (!s)
            return (u << 20) | (32'(r1) << 15) | (32'(f3) << 12) | (32'(r2) << 7) | 32'(op);
        return ((u >> 5) << 25) | (32'(r2) << 20) | (32'(r1) << 15) | (32'(f3) << 12)
             | ((u & 32'h1F) << 7) | 32'(op);
    endfunction

    function automatic int decode_imm(input bit s, input logic [31:0] w);
        logic signed [11:0] t;
        t = s ? {w[31:25], w[11:7]} : w[31:20];
        return int'(t);
    endfunction

    function automatic bit fits(input int im);
        return (im >= -2048) && (im <= 2047);
    endfunction

    task automatic model_reset();
        exp_q.delete();
        exp_addr  = '0;
        exp_errc  = 0;
        exp_pulse = 1'b0;
    endtask

    // Drive one cycle and advance the model with pre-edge state; returns handshake
    task automatic do_cycle(input bit v, input bit s, input logic [2:0] f3, input logic [4:0] r1,
                            input logic [4:0] r2, input int im, input bit ordy, input bit c,
                            output bit acc);
        exp_t e;
        in_valid  = v;
        sel       = s;
        opcode    = s ? OPCODE_STORE : OPCODE_LOAD;
        funct3    = f3;
        rs1       = r1;
        rd_rs2    = r2;
        imm       = 32'(im);
        out_ready = ordy;
        clr       = c;
        acc = v && (exp_q.size() < DP);
        if (c) begin
            model_reset();
        end else begin
            if (exp_q.size() > 0 && ordy) void'(exp_q.pop_front());
            exp_pulse = acc && !fits(im);
            if (acc && fits(im)) begin
                e.instr = ref_enc(s, s ? OPCODE_STORE : OPCODE_LOAD, f3, r1, r2, im);
                e.addr  = exp_addr;
                e.im    = im;
                e.s     = s;
                exp_q.push_back(e);
                exp_addr = exp_addr + AW'(1);
            end else if (acc && exp_errc < 255) begin
                exp_errc++;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        clr      = 1'b0;
    endtask

    task automatic idle(input bit ordy);
        bit a;
        do_cycle(1'b0, 1'b0, 3'd0, 5'd0, 5'd0, 0, ordy, 1'b0, a);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        sel = 1'b0; opcode = '0; funct3 = '0; rs1 = '0; rd_rs2 = '0; imm = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_instr !== 32'h0 || out_addr !== '0 || err_pulse !== 1'b0 || err_count !== 8'h0) begin
            errors++;
            $display("FAIL reset_state: valid=%b instr=%h addr=%0d pulse=%b cnt=%0d, want all zero",
                     out_valid, out_instr, out_addr, err_pulse, err_count);
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_itype();
        bit a;
        do_cycle(1'b1, 1'b0, 3'd2, 5'd2, 5'd5, -4, 1'b0, 1'b0, a);
        checks++;
        if (out_valid !== 1'b1 || out_instr !== 32'hFFC12283 || out_addr !== AW'(0)) begin
            errors++;
            $display("FAIL itype_enc: valid=%b instr=%h addr=%0d, want 1 ffc12283 0", out_valid, out_instr, out_addr);
        end
        idle(1'b1);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL itype_drain: out_valid=%b, want 0", out_valid);
        end
    endtask

    task automatic test_stype();
        bit a;
        do_cycle(1'b1, 1'b1, 3'd2, 5'd3, 5'd6, 2047, 1'b1, 1'b0, a);
        checks++;
        if (out_valid !== 1'b1 || out_instr !== 32'h7E61AFA3 || out_addr !== AW'(1)) begin
            errors++;
            $display("FAIL stype_max: valid=%b instr=%h addr=%0d, want 1 7e61afa3 1", out_valid, out_instr, out_addr);
        end
        do_cycle(1'b1, 1'b1, 3'd2, 5'd3, 5'd6, -2048, 1'b1, 1'b0, a);
        checks++;
        if (out_valid !== 1'b1 || out_instr[31:25] !== 7'h40 || out_instr[11:7] !== 5'h0 || out_addr !== AW'(2)) begin
            errors++;
            $display("FAIL stype_min: valid=%b instr=%h addr=%0d, want hi=40 lo=0 addr=2", out_valid, out_instr, out_addr);
        end
        idle(1'b1);
    endtask

    task automatic test_range_err();
        bit a;
        do_cycle(1'b0, 1'b0, 3'd0, 5'd0, 5'd0, 0, 1'b1, 1'b1, a);
        do_cycle(1'b1, 1'b0, 3'd1, 5'd1, 5'd1, 32'h800, 1'b1, 1'b0, a);
        checks++;
        if (err_pulse !== 1'b1 || err_count !== 8'd1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL range_hi: pulse=%b cnt=%0d valid=%b, want 1 1 0", err_pulse, err_count, out_valid);
        end
        do_cycle(1'b1, 1'b1, 3'd1, 5'd1, 5'd1, int'(32'hFFFFF7FF), 1'b1, 1'b0, a);
        checks++;
        if (err_pulse !== 1'b1 || err_count !== 8'd2 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL range_lo: pulse=%b cnt=%0d valid=%b, want 1 2 0", err_pulse, err_count, out_valid);
        end
        idle(1'b1);
        checks++;
        if (err_pulse !== 1'b0 || err_count !== 8'd2) begin
            errors++;
            $display("FAIL range_pulse_end: pulse=%b cnt=%0d, want 0 2", err_pulse, err_count);
        end
        do_cycle(1'b1, 1'b0, 3'd0, 5'd4, 5'd4, 100, 1'b1, 1'b0, a);
        checks++;
        if (out_valid !== 1'b1 || out_addr !== AW'(0) || out_instr !== 32'h06420203) begin
            errors++;
            $display("FAIL range_next_addr: valid=%b addr=%0d instr=%h, want 1 0 06420203", out_valid, out_addr, out_instr);
        end
        idle(1'b1);
    endtask

    task automatic test_back_to_back();
        bit a;
        logic [AW-1:0] got[$];
        logic [31:0]   held;
        do_cycle(1'b0, 1'b0, 3'd0, 5'd0, 5'd0, 0, 1'b0, 1'b1, a);
        for (int i = 0; i < 2; i++) begin
            do_cycle(1'b1, 1'b0, 3'(i), 5'(i + 1), 5'(i + 7), i * 10, 1'b0, 1'b0, a);
        end
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_full: in_ready=%b, want 0", in_ready);
        end
        held = out_instr;
        do_cycle(1'b1, 1'b0, 3'd2, 5'd3, 5'd9, 20, 1'b0, 1'b0, a);
        checks++;
        if (a || out_instr !== held || out_addr !== AW'(0) || out_instr !== exp_q[0].instr) begin
            errors++;
            $display("FAIL bp_hold: acc=%b instr=%h addr=%0d, want 0 %h 0", a, out_instr, out_addr, held);
        end
        a = 1'b0;
        for (int k = 0; k < 4 && !a; k++) begin
            if (out_valid) got.push_back(out_addr);
            do_cycle(1'b1, 1'b0, 3'd2, 5'd3, 5'd9, 20, 1'b1, 1'b0, a);
        end
        checks++;
        if (!a) begin
            errors++;
            $display("FAIL bp_third_accept: accepted=%b, want 1", a);
        end
        for (int k = 0; k < 8 && out_valid; k++) begin
            checks++;
            if (exp_q.size() == 0 || out_instr !== exp_q[0].instr) begin
                errors++;
                $display("FAIL bp_order: instr=%h, want %h", out_instr, exp_q.size() ? exp_q[0].instr : 32'h0);
            end
            got.push_back(out_addr);
            idle(1'b1);
        end
        checks++;
        if (got.size() != 3 || got[0] !== AW'(0) || got[1] !== AW'(1) || got[2] !== AW'(2)) begin
            errors++;
            $display("FAIL bp_addrs: got %0d words %p, want 0,1,2", got.size(), got);
        end
    endtask

    task automatic test_addr_wrap();
        bit a;
        do_cycle(1'b0, 1'b0, 3'd0, 5'd0, 5'd0, 0, 1'b1, 1'b1, a);
        for (int i = 0; i < 1023; i++) begin
            do_cycle(1'b1, i[0], 3'd1, 5'd1, 5'd2, (i % 4096) - 2048, 1'b1, 1'b0, a);
        end
        idle(1'b1);
        do_cycle(1'b1, 1'b0, 3'd0, 5'd1, 5'd1, 1, 1'b0, 1'b0, a);
        checks++;
        if (out_valid !== 1'b1 || out_addr !== AW'(1023)) begin
            errors++;
            $display("FAIL wrap_top: valid=%b addr=%0d, want 1 1023", out_valid, out_addr);
        end
        do_cycle(1'b1, 1'b0, 3'd0, 5'd1, 5'd1, 2, 1'b1, 1'b0, a);
        checks++;
        if (out_valid !== 1'b1 || out_addr !== AW'(0)) begin
            errors++;
            $display("FAIL wrap_zero: valid=%b addr=%0d, want 1 0", out_valid, out_addr);
        end
        idle(1'b1);
    endtask

    task automatic test_clr_reset();
        bit a;
        do_cycle(1'b1, 1'b0, 3'd0, 5'd0, 5'd0, 5000, 1'b0, 1'b0, a);
        for (int i = 0; i < 2; i++) do_cycle(1'b1, 1'b1, 3'd3, 5'd4, 5'd5, i, 1'b0, 1'b0, a);
        do_cycle(1'b1, 1'b0, 3'd0, 5'd0, 5'd0, 7, 1'b1, 1'b1, a);
        checks++;
        if (out_valid !== 1'b0 || err_count !== 8'd0 || in_ready !== 1'b1 || err_pulse !== 1'b0) begin
            errors++;
            $display("FAIL clr_flush: valid=%b cnt=%0d ready=%b pulse=%b, want 0 0 1 0",
                     out_valid, err_count, in_ready, err_pulse);
        end
        do_cycle(1'b1, 1'b0, 3'd0, 5'd1, 5'd1, 3, 1'b0, 1'b0, a);
        checks++;
        if (out_valid !== 1'b1 || out_addr !== AW'(0)) begin
            errors++;
            $display("FAIL clr_next_addr: valid=%b addr=%0d, want 1 0", out_valid, out_addr);
        end
        do_cycle(1'b1, 1'b0, 3'd0, 5'd1, 5'd1, 4, 1'b0, 1'b0, a);
        rst_n = 1'b0;
        #2;
        model_reset();
        checks++;
        if (out_valid !== 1'b0 || out_instr !== 32'h0 || out_addr !== '0) begin
            errors++;
            $display("FAIL rst_async: valid=%b instr=%h addr=%0d, want 0 0 0", out_valid, out_instr, out_addr);
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_release: valid=%b ready=%b, want 0 1", out_valid, in_ready);
        end
        do_cycle(1'b1, 1'b1, 3'd0, 5'd1, 5'd1, -1, 1'b0, 1'b0, a);
        checks++;
        if (out_valid !== 1'b1 || out_addr !== AW'(0) || out_instr !== exp_q[0].instr) begin
            errors++;
            $display("FAIL rst_next_word: valid=%b addr=%0d instr=%h, want 1 0 %h", out_valid, out_addr, out_instr, exp_q[0].instr);
        end
        idle(1'b1);
    endtask

    task automatic test_random();
        bit a;
        int im;
        for (int n = 0; n < 400; n++) begin
            im = ($urandom_range(0, 9) < 8) ? int'($urandom_range(0, 4095)) - 2048 : int'($urandom);
            checks++;
            if (in_ready !== (exp_q.size() < DP)) begin
                errors++;
                $display("FAIL rnd_ready[%0d]: in_ready=%b, want %b", n, in_ready, exp_q.size() < DP);
            end
            do_cycle($urandom_range(0, 3) != 0, 1'($urandom), 3'($urandom), 5'($urandom), 5'($urandom),
                     im, $urandom_range(0, 2) != 0, $urandom_range(0, 63) == 0, a);
            checks++;
            if (out_valid !== (exp_q.size() > 0) || err_pulse !== exp_pulse || err_count !== 8'(exp_errc)) begin
                errors++;
                $display("FAIL rnd_status[%0d]: valid=%b pulse=%b cnt=%0d, want %b %b %0d",
                         n, out_valid, err_pulse, err_count, exp_q.size() > 0, exp_pulse, exp_errc);
            end
            if (exp_q.size() > 0) begin
                checks++;
                if (out_instr !== exp_q[0].instr || out_addr !== exp_q[0].addr
                    || decode_imm(exp_q[0].s, out_instr) != exp_q[0].im) begin
                    errors++;
                    $display("FAIL rnd_word[%0d]: instr=%h addr=%0d, want %h %0d imm %0d",
                             n, out_instr, out_addr, exp_q[0].instr, exp_q[0].addr, exp_q[0].im);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_itype();
        test_stype();
        test_range_err();
        test_back_to_back();
        test_addr_wrap();
        test_clr_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
